// File: rtl/spi_slave_resp.sv
// spi_slave_resp: SPI responder in front of an 8x8-bit register file.
// Frame = 8 address bits, idle gap, 8 data bits, LSB first, sampled on rising s_clk.
module spi_slave_resp #(
   parameter logic [2:0]  SLAVE_ID    = 3'd0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       s_clk,
   input  logic       mosi,
   input  logic [2:0] ssel,
   output logic       miso,
   output logic       wr_valid,
   output logic [2:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [2:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       txn_done,
   output logic       abort,
   output logic [7:0] txn_cnt,
   output logic       busy
);

   localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t             state, state_nxt;
   logic [NS-1:0]      sclk_sync, mosi_sync, sync_vld;
   logic [NS-1:0][2:0] ssel_sync;
   logic               sclk_prev, sclk_s, mosi_s, sel, rise, fall;
   logic               armed, armed_nxt;
   logic [2:0]         bit_cnt, bit_cnt_nxt;
   logic [7:0]         addr_shift, addr_nxt, rx_shift, rx_nxt, tx_shift, tx_nxt;
   logic [7:0][7:0]    regs;
   logic               reg_we;
   logic               miso_nxt, wr_valid_nxt, txn_done_nxt, abort_nxt, busy_nxt;
   logic [2:0]         wr_addr_nxt;
   logic [7:0]         wr_data_nxt, txn_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sclk_sync <= '1;
         mosi_sync <= '1;
         ssel_sync <= '1;
         sync_vld  <= '0;
         sclk_prev <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[NS-2:0], s_clk};
         mosi_sync <= {mosi_sync[NS-2:0], mosi};
         ssel_sync <= {ssel_sync[NS-2:0], ssel};
         sync_vld  <= {sync_vld[NS-2:0], 1'b1};
         sclk_prev <= sclk_sync[NS-1];
      end
   end

   assign sclk_s  = sclk_sync[NS-1];
   assign mosi_s  = mosi_sync[NS-1];
   assign sel     = (ssel_sync[NS-1] == SLAVE_ID);
   assign rise    = sclk_s & ~sclk_prev;
   assign fall    = ~sclk_s & sclk_prev;
   assign rd_data = regs[rd_idx];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         armed      <= 1'b0;
         bit_cnt    <= '0;
         addr_shift <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         regs       <= '0;
         miso       <= 1'b1;
         wr_valid   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         txn_done   <= 1'b0;
         abort      <= 1'b0;
         txn_cnt    <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         armed      <= armed_nxt;
         bit_cnt    <= bit_cnt_nxt;
         addr_shift <= addr_nxt;
         rx_shift   <= rx_nxt;
         tx_shift   <= tx_nxt;
         miso       <= miso_nxt;
         wr_valid   <= wr_valid_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         txn_done   <= txn_done_nxt;
         abort      <= abort_nxt;
         txn_cnt    <= txn_cnt_nxt;
         busy       <= busy_nxt;
         if (reg_we) regs[addr_shift[2:0]] <= rx_shift;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      addr_nxt     = addr_shift;
      rx_nxt       = rx_shift;
      tx_nxt       = tx_shift;
      miso_nxt     = miso;
      wr_valid_nxt = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      txn_done_nxt = 1'b0;
      abort_nxt    = 1'b0;
      txn_cnt_nxt  = txn_cnt;
      reg_we       = 1'b0;
      // Only a deselect seen after the synchronizers refill re-arms; a frame in flight across reset is ignored.
      armed_nxt    = armed | (~sel & sync_vld[NS-1]);
      case (state)
         IDLE: begin
            miso_nxt = 1'b1;
            if (sel && armed) begin
               state_nxt   = ADDR;
               bit_cnt_nxt = '0;
            end
         end
         ADDR: begin
            if (!sel) begin
               state_nxt = IDLE;
               abort_nxt = 1'b1;
               miso_nxt  = 1'b1;
            end else if (rise) begin
               addr_nxt    = {mosi_s, addr_shift[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
                  if (!addr_nxt[7]) begin
                     tx_nxt   = regs[addr_nxt[2:0]];
                     miso_nxt = tx_nxt[0];
                  end
               end
            end
         end
         DATA: begin
            if (rise && bit_cnt == 3'd7) begin
               state_nxt = DONE;
               miso_nxt  = 1'b1;
               if (addr_shift[7]) rx_nxt = {mosi_s, rx_shift[7:1]};
            end else if (!sel) begin
               state_nxt = IDLE;
               abort_nxt = 1'b1;
               miso_nxt  = 1'b1;
            end else if (rise) begin
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (addr_shift[7]) rx_nxt = {mosi_s, rx_shift[7:1]};
            end else if (fall && !addr_shift[7] && bit_cnt != 3'd0) begin
               // The first data fall precedes the first sample, so bit 0 stays on miso until then.
               tx_nxt   = {1'b1, tx_shift[7:1]};
               miso_nxt = tx_shift[1];
            end
         end
         DONE: begin
            miso_nxt     = 1'b1;
            txn_done_nxt = 1'b1;
            txn_cnt_nxt  = txn_cnt + 8'd1;
            bit_cnt_nxt  = '0;
            if (addr_shift[7]) begin
               reg_we       = 1'b1;
               wr_valid_nxt = 1'b1;
               wr_addr_nxt  = addr_shift[2:0];
               wr_data_nxt  = rx_shift;
            end
            state_nxt = sel ? ADDR : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == ADDR) || (state_nxt == DATA);
   end

endmodule
